// File: rtl/reservation_station_if.sv
// Dispatch, bypass and issue bundle for the reservation station.
//   slave  : reservation-station side (takes dispatch/bypass, drives rs_full and rs2alu_*)
//   master : environment side (dispatcher, bypass producers, ALU)
interface reservation_station_if #(
    parameter int unsigned ROB_BITS  = 4,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned TYPE_BITS = 6
);
    // dispatch
    logic                 dsp_enable;
    logic [TYPE_BITS-1:0] dsp_ins_type;
    logic                 dsp_rs1_ready;
    logic                 dsp_rs2_ready;
    logic [DATA_BITS-1:0] dsp_rs1_value;
    logic [DATA_BITS-1:0] dsp_rs2_value;
    logic [ROB_BITS-1:0]  dsp_rs1_reorder;
    logic [ROB_BITS-1:0]  dsp_rs2_reorder;
    logic [DATA_BITS-1:0] dsp_imm;
    logic [DATA_BITS-1:0] dsp_pc;
    logic [ROB_BITS-1:0]  dsp_reorder;
    logic                 rs_full;
    // bypass buses
    logic                 alu_bp_enable;
    logic [ROB_BITS-1:0]  alu_bp_reorder;
    logic [DATA_BITS-1:0] alu_bp_value;
    logic                 lsb_bp_enable;
    logic [ROB_BITS-1:0]  lsb_bp_reorder;
    logic [DATA_BITS-1:0] lsb_bp_value;
    // issue to ALU
    logic                 rs2alu_enable;
    logic [DATA_BITS-1:0] rs2alu_rs1;
    logic [DATA_BITS-1:0] rs2alu_rs2;
    logic [DATA_BITS-1:0] rs2alu_imm;
    logic [TYPE_BITS-1:0] rs2alu_ins_type;
    logic [DATA_BITS-1:0] rs2alu_pc;
    logic [ROB_BITS-1:0]  rs2alu_reorder;

    modport slave (
        input  dsp_enable, dsp_ins_type, dsp_rs1_ready, dsp_rs2_ready,
               dsp_rs1_value, dsp_rs2_value, dsp_rs1_reorder, dsp_rs2_reorder,
               dsp_imm, dsp_pc, dsp_reorder,
               alu_bp_enable, alu_bp_reorder, alu_bp_value,
               lsb_bp_enable, lsb_bp_reorder, lsb_bp_value,
        output rs_full, rs2alu_enable, rs2alu_rs1, rs2alu_rs2, rs2alu_imm,
               rs2alu_ins_type, rs2alu_pc, rs2alu_reorder
    );

    modport master (
        output dsp_enable, dsp_ins_type, dsp_rs1_ready, dsp_rs2_ready,
               dsp_rs1_value, dsp_rs2_value, dsp_rs1_reorder, dsp_rs2_reorder,
               dsp_imm, dsp_pc, dsp_reorder,
               alu_bp_enable, alu_bp_reorder, alu_bp_value,
               lsb_bp_enable, lsb_bp_reorder, lsb_bp_value,
        input  rs_full, rs2alu_enable, rs2alu_rs1, rs2alu_rs2, rs2alu_imm,
               rs2alu_ins_type, rs2alu_pc, rs2alu_reorder
    );
endinterface

// File: rtl/reservation_station.sv
// Out-of-order issue buffer in front of the combinational ALU.
// Holds dispatched instructions until both operands are valid, snoops the
// ALU and LSB bypass buses, and issues at most one ready entry per cycle on
// a registered interface.
//   clk_in  : clock
//   rst_in  : asynchronous reset, active-low
//   rdy_in  : global ready, low freezes the block
//   clear   : synchronous flush of all entries
//   bus     : dispatch / bypass / issue bundle (slave side)
module reservation_station #(
    parameter int unsigned RS_SIZE   = 16,
    parameter int unsigned ROB_BITS  = 4,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned TYPE_BITS = 6
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic clear,
    reservation_station_if.slave bus
);
    localparam int unsigned IDX_BITS = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // entry state
    logic [RS_SIZE-1:0]   r_busy;
    logic [RS_SIZE-1:0]   r_rdy1;
    logic [RS_SIZE-1:0]   r_rdy2;
    logic [DATA_BITS-1:0] r_val1 [RS_SIZE];
    logic [DATA_BITS-1:0] r_val2 [RS_SIZE];
    logic [ROB_BITS-1:0]  r_tag1 [RS_SIZE];
    logic [ROB_BITS-1:0]  r_tag2 [RS_SIZE];
    logic [TYPE_BITS-1:0] r_type [RS_SIZE];
    logic [DATA_BITS-1:0] r_imm  [RS_SIZE];
    logic [DATA_BITS-1:0] r_pc   [RS_SIZE];
    logic [ROB_BITS-1:0]  r_dest [RS_SIZE];

    // issue registers
    logic                 r_out_en;
    logic [DATA_BITS-1:0] r_out_rs1;
    logic [DATA_BITS-1:0] r_out_rs2;
    logic [DATA_BITS-1:0] r_out_imm;
    logic [TYPE_BITS-1:0] r_out_type;
    logic [DATA_BITS-1:0] r_out_pc;
    logic [ROB_BITS-1:0]  r_out_dest;

    logic                 w_full;
    logic                 w_free_vld;
    logic [IDX_BITS-1:0]  w_free_idx;
    logic                 w_iss_vld;
    logic [IDX_BITS-1:0]  w_iss_idx;
    logic                 w_dsp_go;
    logic                 w_upd;
    logic                 w_dsp_rdy1;
    logic                 w_dsp_rdy2;
    logic [DATA_BITS-1:0] w_dsp_val1;
    logic [DATA_BITS-1:0] w_dsp_val2;

    // Resolve a not-ready operand against the bypass buses; ALU wins on a tie.
    function automatic logic [DATA_BITS:0] snoop(
        input logic                 rdy,
        input logic [DATA_BITS-1:0] val,
        input logic [ROB_BITS-1:0]  tag
    );
        if (rdy)                                                  return {1'b1, val};
        else if (bus.alu_bp_enable && bus.alu_bp_reorder == tag) return {1'b1, bus.alu_bp_value};
        else if (bus.lsb_bp_enable && bus.lsb_bp_reorder == tag) return {1'b1, bus.lsb_bp_value};
        else                                                      return {1'b0, val};
    endfunction

    // An entry issuing this cycle still counts as busy here.
    assign w_full   = &r_busy;
    assign w_upd    = rdy_in && !clear;
    assign w_dsp_go = w_upd && bus.dsp_enable && !w_full && w_free_vld;

    always_comb begin
        w_free_vld = 1'b0;
        w_free_idx = '0;
        w_iss_vld  = 1'b0;
        w_iss_idx  = '0;
        // scan downwards so the lowest index is the last one assigned
        for (int unsigned i = RS_SIZE; i > 0; i--) begin
            if (!r_busy[i-1]) begin
                w_free_vld = 1'b1;
                w_free_idx = IDX_BITS'(i-1);
            end
            if (r_busy[i-1] && r_rdy1[i-1] && r_rdy2[i-1]) begin
                w_iss_vld = 1'b1;
                w_iss_idx = IDX_BITS'(i-1);
            end
        end
    end

    always_comb begin
        {w_dsp_rdy1, w_dsp_val1} = snoop(bus.dsp_rs1_ready, bus.dsp_rs1_value, bus.dsp_rs1_reorder);
        {w_dsp_rdy2, w_dsp_val2} = snoop(bus.dsp_rs2_ready, bus.dsp_rs2_value, bus.dsp_rs2_reorder);
    end

    // busy flags and issue registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy     <= '0;
            r_out_en   <= 1'b0;
            r_out_rs1  <= '0;
            r_out_rs2  <= '0;
            r_out_imm  <= '0;
            r_out_type <= '0;
            r_out_pc   <= '0;
            r_out_dest <= '0;
        end else if (!rdy_in) begin
            r_out_en <= 1'b0;
        end else if (clear) begin
            r_busy   <= '0;
            r_out_en <= 1'b0;
        end else begin
            r_out_en <= w_iss_vld;
            if (w_iss_vld) begin
                r_busy[w_iss_idx] <= 1'b0;
                r_out_rs1  <= r_val1[w_iss_idx];
                r_out_rs2  <= r_val2[w_iss_idx];
                r_out_imm  <= r_imm[w_iss_idx];
                r_out_type <= r_type[w_iss_idx];
                r_out_pc   <= r_pc[w_iss_idx];
                r_out_dest <= r_dest[w_iss_idx];
            end
            // free slot is never the issuing one, so the two writes never collide
            if (w_dsp_go) begin
                r_busy[w_free_idx] <= 1'b1;
            end
        end
    end

    // entry payload: wake-up on busy entries, then dispatch write
    always_ff @(posedge clk_in) begin
        if (w_upd) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    {r_rdy1[i], r_val1[i]} <= snoop(r_rdy1[i], r_val1[i], r_tag1[i]);
                    {r_rdy2[i], r_val2[i]} <= snoop(r_rdy2[i], r_val2[i], r_tag2[i]);
                end
            end
            if (w_dsp_go) begin
                r_rdy1[w_free_idx] <= w_dsp_rdy1;
                r_val1[w_free_idx] <= w_dsp_val1;
                r_tag1[w_free_idx] <= bus.dsp_rs1_reorder;
                r_rdy2[w_free_idx] <= w_dsp_rdy2;
                r_val2[w_free_idx] <= w_dsp_val2;
                r_tag2[w_free_idx] <= bus.dsp_rs2_reorder;
                r_type[w_free_idx] <= bus.dsp_ins_type;
                r_imm[w_free_idx]  <= bus.dsp_imm;
                r_pc[w_free_idx]   <= bus.dsp_pc;
                r_dest[w_free_idx] <= bus.dsp_reorder;
            end
        end
    end

    assign bus.rs_full         = w_full;
    assign bus.rs2alu_enable   = r_out_en;
    assign bus.rs2alu_rs1      = r_out_rs1;
    assign bus.rs2alu_rs2      = r_out_rs2;
    assign bus.rs2alu_imm      = r_out_imm;
    assign bus.rs2alu_ins_type = r_out_type;
    assign bus.rs2alu_pc       = r_out_pc;
    assign bus.rs2alu_reorder  = r_out_dest;
endmodule
